// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register of the five-stage RV32I core. Each cycle it latches
//   the decoder's control word and operands for the execute stage, detects
//   load-use hazards against the load currently sitting in EX, and:
//     - squashes the decode-stage instruction when EX redirects the PC,
//     - freezes completely while the back end asks for a hold,
//     - inserts a single bubble on a load-use hazard (load_use_stall tells the
//       front end to keep PC and IF/ID for that cycle).
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> bubble_cnt / flush_cnt count load-use bubbles and flushes
//   undefined -> both counter outputs tie to 0, no counter flops
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   id_valid                     decode slot holds a real instruction
//   id_pc/id_rd1/id_rd2/id_imm   PC, register read data, immediate (XLEN)
//   id_rs1/id_rs2/id_rd          register indices (5)
//   id_rR1_use/id_rR2_use        decoder source-use flags
//   id_rf_we/id_dram_we          write enables
//   id_asel/id_bsel              ALU operand selects
//   id_wbsel[1:0]                writeback select, 2 = load
//   id_alu_op[3:0]               ALU operation
//   ex_redirect                  EX took a branch/jump this cycle
//   ext_hold                     back-end freeze request
//   ex_*                         registered copies of the id_* fields
//   load_use_stall               combinational: hold PC and IF/ID this cycle
//   bubble_cnt/flush_cnt         performance counters (32)
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rR1_use,
  input  logic            id_rR2_use,
  input  logic            id_rf_we,
  input  logic            id_dram_we,
  input  logic            id_asel,
  input  logic            id_bsel,
  input  logic [1:0]      id_wbsel,
  input  logic [3:0]      id_alu_op,
  input  logic            ex_redirect,
  input  logic            ext_hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_rf_we,
  output logic            ex_dram_we,
  output logic            ex_asel,
  output logic            ex_bsel,
  output logic [1:0]      ex_wbsel,
  output logic [3:0]      ex_alu_op,
  output logic            load_use_stall,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
);

  localparam logic [1:0] WB_LOAD    = 2'd2;
  localparam logic [1:0] WB_BUBBLE  = 2'd1;
  localparam logic [3:0] ALU_BUBBLE = 4'hF;

  // Everything EX sees from this register, held as one word so bubble,
  // hold and capture are single assignments.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rf_we;
    logic            dram_we;
    logic            asel;
    logic            bsel;
    logic [1:0]      wbsel;
    logic [3:0]      alu_op;
  } ex_word_t;

  // A bubble is a harmless no-op: no writes, writeback select off the load
  // path, and an ALU op code that the execute stage treats as idle.
  localparam ex_word_t BUBBLE_WORD = '{
    valid:   1'b0,
    pc:      '0,
    rd1:     '0,
    rd2:     '0,
    imm:     '0,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    rf_we:   1'b0,
    dram_we: 1'b0,
    asel:    1'b0,
    bsel:    1'b0,
    wbsel:   WB_BUBBLE,
    alu_op:  ALU_BUBBLE
  };

  ex_word_t ex_q;
  ex_word_t ex_d;
  ex_word_t id_word;

  // Decode-stage word; an empty slot can never write state even if the
  // decoder left stale enables on its outputs.
  always_comb begin
    id_word         = BUBBLE_WORD;
    id_word.valid   = id_valid;
    id_word.pc      = id_pc;
    id_word.rd1     = id_rd1;
    id_word.rd2     = id_rd2;
    id_word.imm     = id_imm;
    id_word.rs1     = id_rs1;
    id_word.rs2     = id_rs2;
    id_word.rd      = id_rd;
    id_word.rf_we   = id_rf_we & id_valid;
    id_word.dram_we = id_dram_we & id_valid;
    id_word.asel    = id_asel;
    id_word.bsel    = id_bsel;
    id_word.wbsel   = id_wbsel;
    id_word.alu_op  = id_alu_op;
  end

  // Load-use hazard. A load into x0 produces nothing to forward, so it never
  // stalls. Redirect and hold both gate the stall: a squashed instruction
  // needs no interlock and a frozen pipe must not also freeze the front end
  // on a stale compare.
  logic load_in_ex;
  logic src1_hit;
  logic src2_hit;

  assign load_in_ex = ex_q.valid && (ex_q.wbsel == WB_LOAD) && (ex_q.rd != 5'd0);
  assign src1_hit   = id_rR1_use && (id_rs1 == ex_q.rd);
  assign src2_hit   = id_rR2_use && (id_rs2 == ex_q.rd);

  assign load_use_stall = load_in_ex && id_valid && (src1_hit || src2_hit)
                          && !ex_redirect && !ext_hold;

  // Update priority: flush > hold > load-use bubble > capture.
  always_comb begin
    ex_d = ex_q;
    if (ex_redirect)         ex_d = BUBBLE_WORD;
    else if (ext_hold)       ex_d = ex_q;
    else if (load_use_stall) ex_d = BUBBLE_WORD;
    else                     ex_d = id_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= BUBBLE_WORD;
    else     ex_q <= ex_d;
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_rd1     = ex_q.rd1;
  assign ex_rd2     = ex_q.rd2;
  assign ex_imm     = ex_q.imm;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_rf_we   = ex_q.rf_we;
  assign ex_dram_we = ex_q.dram_we;
  assign ex_asel    = ex_q.asel;
  assign ex_bsel    = ex_q.bsel;
  assign ex_wbsel   = ex_q.wbsel;
  assign ex_alu_op  = ex_q.alu_op;

`ifdef PIPE_PERF_CNT_EN
  // load_use_stall is already low under hold or redirect, so it alone marks
  // a hazard bubble; a redirect counts as a flush even while held.
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'd0;
      flush_cnt_q  <= 32'd0;
    end else begin
      if (load_use_stall) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (ex_redirect)    flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rR1_use, id_rR2_use, id_rf_we, id_dram_we, id_asel, id_bsel;
  logic [1:0]  id_wbsel;
  logic [3:0]  id_alu_op;
  logic        ex_redirect, ext_hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rf_we, ex_dram_we, ex_asel, ex_bsel;
  logic [1:0]  ex_wbsel;
  logic [3:0]  ex_alu_op;
  logic        load_use_stall;
  logic [31:0] bubble_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rR1_use(id_rR1_use), .id_rR2_use(id_rR2_use),
    .id_rf_we(id_rf_we), .id_dram_we(id_dram_we), .id_asel(id_asel), .id_bsel(id_bsel),
    .id_wbsel(id_wbsel), .id_alu_op(id_alu_op),
    .ex_redirect(ex_redirect), .ext_hold(ext_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .ex_dram_we(ex_dram_we), .ex_asel(ex_asel), .ex_bsel(ex_bsel),
    .ex_wbsel(ex_wbsel), .ex_alu_op(ex_alu_op),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Reference view of "the instruction sitting in EX".
  typedef struct packed {
    logic        v;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rf_we, dram_we, asel, bsel;
    logic [1:0]  wbsel;
    logic [3:0]  alu_op;
  } rec_t;

  rec_t        m;
  logic [31:0] m_bub, m_flush;

  function automatic rec_t bubble_rec();
    rec_t r = '0;
    r.wbsel  = 2'd1;
    r.alu_op = 4'd15;
    return r;
  endfunction

  function automatic rec_t id_rec();
    rec_t r;
    r.v = id_valid; r.pc = id_pc; r.rd1 = id_rd1; r.rd2 = id_rd2; r.imm = id_imm;
    r.rs1 = id_rs1; r.rs2 = id_rs2; r.rd = id_rd;
    r.rf_we   = id_valid ? id_rf_we : 1'b0;
    r.dram_we = id_valid ? id_dram_we : 1'b0;
    r.asel = id_asel; r.bsel = id_bsel; r.wbsel = id_wbsel; r.alu_op = id_alu_op;
    return r;
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r.v = ex_valid; r.pc = ex_pc; r.rd1 = ex_rd1; r.rd2 = ex_rd2; r.imm = ex_imm;
    r.rs1 = ex_rs1; r.rs2 = ex_rs2; r.rd = ex_rd;
    r.rf_we = ex_rf_we; r.dram_we = ex_dram_we; r.asel = ex_asel; r.bsel = ex_bsel;
    r.wbsel = ex_wbsel; r.alu_op = ex_alu_op;
    return r;
  endfunction

  // A real load into a real register, and a decode instruction that reads it.
  function automatic logic exp_stall();
    logic dep;
    if (ex_redirect || ext_hold) return 1'b0;
    if (!(m.v && m.wbsel == 2'd2 && m.rd != 5'd0 && id_valid)) return 1'b0;
    dep = (id_rR1_use && id_rs1 == m.rd) || (id_rR2_use && id_rs2 == m.rd);
    return dep;
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m = bubble_rec(); m_bub = 0; m_flush = 0;
  endtask

  // Advance the reference by one edge using the inputs currently applied.
  task automatic model_edge();
    logic st;
    st = exp_stall();
    if (ex_redirect) begin
      m = bubble_rec();
`ifdef PIPE_PERF_CNT_EN
      m_flush = m_flush + 1;
`endif
    end else if (ext_hold) begin
      m = m;
    end else if (st) begin
      m = bubble_rec();
`ifdef PIPE_PERF_CNT_EN
      m_bub = m_bub + 1;
`endif
    end else begin
      m = id_rec();
    end
  endtask

  // Called mid-cycle after inputs are set: check the stall, clock, check EX.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".stall"}, {159'd0, load_use_stall}, {159'd0, exp_stall()});
    model_edge();
    @(posedge clk); #1;
    chk({tag, ".ex"}, {6'd0, dut_rec()}, {6'd0, m});
    chk({tag, ".cnt"}, {96'd0, bubble_cnt, flush_cnt}, {96'd0, m_bub, m_flush});
  endtask

  task automatic rand_id();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_pc      = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1     = 5'($urandom_range(0, 3));
    id_rs2     = 5'($urandom_range(0, 3));
    id_rd      = 5'($urandom_range(0, 3));
    id_rR1_use = 1'($urandom); id_rR2_use = 1'($urandom);
    id_rf_we   = 1'($urandom); id_dram_we = 1'($urandom);
    id_asel    = 1'($urandom); id_bsel    = 1'($urandom);
    id_wbsel   = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom);
    id_alu_op  = 4'($urandom);
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic [1:0] wb,
                           input logic rfwe, input logic dwe);
    id_valid = 1'b1; id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rR1_use = u1; id_rR2_use = u2;
    id_wbsel = wb; id_rf_we = rfwe; id_dram_we = dwe;
    id_asel = 1'b0; id_bsel = 1'b1; id_alu_op = 4'd0;
  endtask

  rec_t held;

  initial begin
    // Reset with random inputs: outputs go to bubble asynchronously.
    ex_redirect = 0; ext_hold = 0; rst = 0;
    rand_id();
    @(negedge clk);
    rst = 1; #1;
    model_reset();
    chk("reset.ex", {6'd0, dut_rec()}, {6'd0, m});
    chk("reset.alu_op", {156'd0, ex_alu_op}, {156'd0, 4'd15});
    chk("reset.cnt", {96'd0, bubble_cnt, flush_cnt}, 160'd0);
    @(posedge clk); #1;
    chk("reset.held", {6'd0, dut_rec()}, {6'd0, m});
    @(negedge clk); rst = 0;

    // Capture resumes on the first edge after release.
    set_instr(5'd1, 5'd2, 5'd3, 1, 1, 2'd0, 1, 0);
    cycle("first_capture");

    // Load-use: lw x5 then add x6,x5,x7.
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 2'd2, 1, 0);
    cycle("lu.load");
    set_instr(5'd5, 5'd7, 5'd6, 1, 1, 2'd0, 1, 0);
    #1;
    chk("lu.stall_hi", {159'd0, load_use_stall}, {159'd0, 1'b1});
    cycle("lu.bubble");
    chk("lu.bubble_valid", {159'd0, ex_valid}, 160'd0);
    cycle("lu.add");
`ifdef PIPE_PERF_CNT_EN
    chk("lu.bubble_cnt", {128'd0, bubble_cnt}, {128'd0, 32'd1});
`endif

    // Back-to-back dependent loads each stall once.
    set_instr(5'd6, 5'd0, 5'd8, 1, 0, 2'd2, 1, 0);
    cycle("b2b.load1");
    set_instr(5'd8, 5'd0, 5'd9, 1, 0, 2'd2, 1, 0);
    cycle("b2b.stall1");
    cycle("b2b.load2");
    set_instr(5'd0, 5'd9, 5'd10, 0, 1, 2'd0, 1, 0);
    cycle("b2b.stall2");
    cycle("b2b.use");

    // No false stall: load to x0, and lui with no source use.
    set_instr(5'd1, 5'd0, 5'd0, 1, 0, 2'd2, 1, 0);
    cycle("nf.load_x0");
    set_instr(5'd0, 5'd0, 5'd4, 1, 1, 2'd0, 1, 0);
    #1;
    chk("nf.x0_stall", {159'd0, load_use_stall}, 160'd0);
    cycle("nf.x0_use");
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 2'd2, 1, 0);
    cycle("nf.load_x5");
    set_instr(5'd5, 5'd5, 5'd6, 0, 0, 2'd0, 1, 0);
    #1;
    chk("nf.lui_stall", {159'd0, load_use_stall}, 160'd0);
    cycle("nf.lui");

    // Redirect over a valid sw that also has a hazard with the load in EX.
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 2'd2, 1, 0);
    cycle("rd.load");
    set_instr(5'd5, 5'd3, 5'd0, 1, 1, 2'd0, 0, 1);
    ex_redirect = 1;
    #1;
    chk("rd.no_stall", {159'd0, load_use_stall}, 160'd0);
    cycle("rd.flush");
    chk("rd.dram_we", {159'd0, ex_dram_we}, 160'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("rd.flush_cnt", {128'd0, flush_cnt}, {128'd0, 32'd1});
`endif
    ex_redirect = 0;

    // Hold for three cycles with changing inputs, then release.
    set_instr(5'd2, 5'd3, 5'd4, 1, 1, 2'd0, 1, 0);
    cycle("hold.pre");
    held = m;
    ext_hold = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle("hold.cyc");
      chk("hold.const", {6'd0, dut_rec()}, {6'd0, held});
    end
    ext_hold = 0;
    rand_id(); id_valid = 1; id_wbsel = 2'd0;
    cycle("hold.release");

    // Redirect and hold together: flush wins.
    ext_hold = 1; ex_redirect = 1; rand_id();
    cycle("rdhold");
    ext_hold = 0; ex_redirect = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      ex_redirect = ($urandom_range(0, 9) == 0);
      ext_hold    = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    ex_redirect = 0; ext_hold = 0;

    // Reset in the middle of a hold clears at once.
    set_instr(5'd1, 5'd2, 5'd3, 1, 1, 2'd2, 1, 0);
    cycle("mid.capture");
    ext_hold = 1; rand_id();
    #2; rst = 1; #1;
    model_reset();
    chk("mid.reset", {6'd0, dut_rec()}, {6'd0, m});
    @(negedge clk); rst = 0; ext_hold = 0;
    rand_id();
    cycle("mid.after");

`ifdef PIPE_PERF_CNT_EN
    // Counter wrap.
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 2'd2, 1, 0);
    cycle("wrap.load");
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    m_bub = 32'hFFFF_FFFF;
    set_instr(5'd5, 5'd0, 5'd6, 1, 0, 2'd0, 1, 0);
    cycle("wrap.stall");
    chk("wrap.zero", {128'd0, bubble_cnt}, 160'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
